// File: rtl/montgomery_product.sv
// montgomery_product: iterative Montgomery multiplier, result = a*b*2^-WIDTH mod N.
// Optional feature macro MONT_RADIX4_EN: retire two multiplier bits per cycle
// (latency WIDTH/2+1 instead of WIDTH+1); results are identical either way.
module montgomery_product #(
  parameter int WIDTH = 256,
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] N,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  // Accumulator carries two guard bits: m1 + N < 4N never overflows.
  localparam int MW = WIDTH + 2;

`ifdef MONT_RADIX4_EN
  localparam int                STEP = 2;
`else
  localparam int                STEP = 1;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - STEP);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

  state_t           r_state, w_next;
  logic [MW-1:0]    r_n, r_b, r_m;
  logic [WIDTH-1:0] r_a;      // shifted right as bits are consumed, LSB = current bit
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_result;
  logic             r_done;

  logic [MW-1:0]    w_m_next, w_m_sub;
  logic [WIDTH-1:0] w_fix;
  logic             w_last;

  // One radix-2 step: add b if the multiplier bit is set, make even with N, halve.
  function automatic logic [MW-1:0] mont_step(input logic [MW-1:0] m, input logic abit,
                                              input logic [MW-1:0] bx, input logic [MW-1:0] nx);
    logic [MW-1:0] m1, m2;
    m1 = m + (abit ? bx : '0);
    m2 = m1[0] ? m1 + nx : m1;
    return m2 >> 1;
  endfunction

  // Iteration datapath and final conditional subtract.
  always_comb begin
`ifdef MONT_RADIX4_EN
    w_m_next = mont_step(mont_step(r_m, r_a[0], r_b, r_n), r_a[1], r_b, r_n);
`else
    w_m_next = mont_step(r_m, r_a[0], r_b, r_n);
`endif
    w_m_sub = r_m - r_n;
    w_fix   = (r_m >= r_n) ? w_m_sub[WIDTH-1:0] : r_m[WIDTH-1:0];
    w_last  = (r_cnt == LAST);
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; start is only looked at while idle, so busy requests drop.
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CALC;
      S_CALC:  if (w_last) w_next = S_FIX;
      S_FIX:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Operand latch, iteration registers, result and one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_n      <= '0;
      r_a      <= '0;
      r_b      <= '0;
      r_m      <= '0;
      r_cnt    <= '0;
      r_result <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_n   <= {2'b00, N};
          r_a   <= a;
          r_b   <= {2'b00, b};
          r_m   <= '0;
          r_cnt <= '0;
        end
        S_CALC: begin
          r_m   <= w_m_next;
          r_a   <= r_a >> STEP;
          r_cnt <= r_cnt + CNT_W'(STEP);
        end
        S_FIX: begin
          r_result <= w_fix;
          r_done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign result = r_result;
  assign done   = r_done;

endmodule

// File: tb/tb_montgomery_product.sv
// Scoreboard bench for montgomery_product, WIDTH=8, N=13 (2^-8 mod 13 = 3).
module tb_montgomery_product;
  localparam int W  = 8;
  localparam int CW = 4;
`ifdef MONT_RADIX4_EN
  localparam int LAT = 5;
`else
  localparam int LAT = 9;
`endif

  logic         clk = 1'b0, rst_n = 1'b0, start = 1'b0;
  logic [W-1:0] N = 8'd13, a = '0, b = '0;
  logic [W-1:0] result;
  logic         done;

  montgomery_product #(.WIDTH(W), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .N(N), .a(a), .b(b),
    .result(result), .done(done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { logic [W-1:0] res; int due; string name; } exp_t;
  exp_t sb[$];
  int   n_vec = 0, n_err = 0, n_done = 0;
  logic prev_done = 1'b0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  // Monitor: every done pulse is matched against the oldest expected entry.
  always @(negedge clk) begin : mon
    exp_t e;
    if (done) begin
      n_done++;
      chk("done_single_cycle", prev_done, 0);
      if (sb.size() == 0) begin
        n_vec++; n_err++;
        $display("FAIL unexpected_done: done at cycle %0d with nothing outstanding", cyc);
      end else begin
        e = sb.pop_front();
        chk({e.name, "_result"}, result, e.res);
        chk({e.name, "_cycle"},  cyc,    e.due);
      end
    end
    prev_done = done;
  end

  task automatic issue(input logic [W-1:0] av, input logic [W-1:0] bv,
                       input logic [W-1:0] ex, input string nm, input bit expect_done);
    @(negedge clk);
    a = av; b = bv; start = 1'b1;
    if (expect_done) sb.push_back('{ex, cyc + 1 + LAT, nm});
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic drain(input string nm);
    for (int i = 0; i < 60; i++) begin
      if (sb.size() == 0) break;
      @(negedge clk);
    end
    @(negedge clk);
    chk({nm, "_outstanding"}, sb.size(), 0);
    sb.delete();
  endtask

  task automatic wait_done();
    bit ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (done) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      n_vec++; n_err++;
      $display("FAIL wait_done: no done within 40 cycles, got 0 expected 1");
    end
  endtask

  logic [W-1:0] va[7] = '{8'd5, 8'd9, 8'd1, 8'd0,  8'd12, 8'd3, 8'd0};
  logic [W-1:0] vb[7] = '{8'd7, 8'd7, 8'd1, 8'd12, 8'd1,  8'd4, 8'd0};
  logic [W-1:0] ve[7] = '{8'd1, 8'd7, 8'd3, 8'd0,  8'd10, 8'd10, 8'd0};
  logic [W-1:0] ba[3] = '{8'd9, 8'd1, 8'd2};
  logic [W-1:0] bb[3] = '{8'd7, 8'd1, 8'd11};
  logic [W-1:0] be[3] = '{8'd7, 8'd3, 8'd1};

  initial begin
    int d0;
    // Reset and idle.
    repeat (3) @(negedge clk);
    chk("rst_result", result, 0);
    chk("rst_done",   done,   0);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("idle_result", result, 0);
      chk("idle_done",   done,   0);
    end

    // Directed single operations.
    for (int i = 0; i < 7; i++) begin
      issue(va[i], vb[i], ve[i], $sformatf("vec%0d", i), 1'b1);
      drain($sformatf("vec%0d", i));
    end

    // Start pulsed while busy must be dropped.
    d0 = n_done;
    issue(8'd5, 8'd7, 8'd1, "ignore", 1'b1);
    repeat (3) @(negedge clk);
    a = 8'd1; b = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    drain("ignore");
    chk("ignore_done_count", n_done - d0, 1);

    // Start held high: back-to-back ops, new operands presented while done is high.
    @(negedge clk);
    a = ba[0]; b = bb[0]; start = 1'b1;
    sb.push_back('{be[0], cyc + 1 + LAT, "b2b0"});
    for (int k = 1; k < 3; k++) begin
      wait_done();
      a = ba[k]; b = bb[k];
      sb.push_back('{be[k], cyc + 1 + LAT, $sformatf("b2b%0d", k)});
    end
    wait_done();
    start = 1'b0;
    drain("b2b");

    // Reset during iteration 4 aborts without a done pulse.
    d0 = n_done;
    issue(8'd3, 8'd4, 8'd0, "abort", 1'b0);
    repeat (3) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_result", result, 0);
    chk("abort_done",   done,   0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (12) @(negedge clk);
    chk("abort_no_done", n_done - d0, 0);
    issue(8'd12, 8'd12, 8'd3, "restart", 1'b1);
    drain("restart");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
